// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage RV32I core.
// Produces fetch/decode stall and decode/execute flush controls, Decode and
// Execute forwarding selects, a boot/stall sequencing FSM, a sticky stall
// overrun flag and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_STALL   = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic             BranchD,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic             LoadE,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteM,
    input  logic [4:0]       RDW,
    input  logic             RegWriteW,
    input  logic             Branch_resultE,
    input  logic             JalE,
    input  logic             JalrE,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAEDec,
    output logic [1:0]       ForwardBEDec,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             stall_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
    localparam int RW = $clog2(MAX_STALL + 2);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_STALL} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BW-1:0]   r_boot_cnt;
    logic [RW-1:0]   r_run_cnt;
    logic            r_err;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic w_lu_hz;
    logic w_br_hz;
    logic w_hz;
    logic w_redirect;
    logic w_err_set;

    // Register x0 is hardwired to zero, so a zero address never matches.
    function automatic logic match(input logic [4:0] rd, input logic [4:0] src);
        return (src != 5'd0) && (rd == src);
    endfunction

    // Hazard and redirect detection from the stage addresses and flags.
    always_comb begin
        w_lu_hz    = LoadE & (match(RD_E, RS1_D) | match(RD_E, RS2_D));
        w_br_hz    = BranchD &
                     ((RegWriteE & (match(RD_E, RS1_D) | match(RD_E, RS2_D))) |
                      (RegWriteM & (match(RD_M, RS1_D) | match(RD_M, RS2_D))));
        w_hz       = w_lu_hz | w_br_hz;
        w_redirect = Branch_resultE | JalE | JalrE;
    end

    // Forwarding selects; Memory stage has priority over Writeback in Execute.
    always_comb begin
        ForwardAEDec = (RegWriteW & match(RDW, RS1_D)) ? 2'b01 : 2'b00;
        ForwardBEDec = (RegWriteW & match(RDW, RS2_D)) ? 2'b01 : 2'b00;
        if (RegWriteM & match(RD_M, RS1_E))      ForwardAE = 2'b10;
        else if (RegWriteW & match(RDW, RS1_E))  ForwardAE = 2'b01;
        else                                     ForwardAE = 2'b00;
        if (RegWriteM & match(RD_M, RS2_E))      ForwardBE = 2'b10;
        else if (RegWriteW & match(RDW, RS2_E))  ForwardBE = 2'b01;
        else                                     ForwardBE = 2'b00;
    end

    // FSM next state and zero-latency stall/flush controls.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        case (r_state)
            ST_BOOT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (r_boot_cnt == BW'(BOOT_CYCLES - 1)) w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (w_redirect) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (w_hz) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                if (r_state == ST_RUN) begin
                    if (w_hz && !w_redirect) w_state_nxt = ST_STALL;
                end else begin
                    if (!w_hz || w_redirect) w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // The (MAX_STALL+1)th consecutive stall cycle raises the overrun flag.
    assign w_err_set = (r_state == ST_STALL) && w_hz && !w_redirect &&
                       (r_run_cnt == RW'(MAX_STALL - 1));

    // State, boot/stall-run counters and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= '0;
            r_run_cnt  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= (r_state == ST_BOOT) ? r_boot_cnt + BW'(1) : '0;
            if (r_state == ST_STALL && w_state_nxt == ST_STALL) begin
                if (r_run_cnt != RW'(MAX_STALL + 1)) r_run_cnt <= r_run_cnt + RW'(1);
            end else begin
                r_run_cnt <= '0;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    // Saturating performance counters; clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (cnt_clr) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (r_state != ST_BOOT) begin
            if (StallD && (r_stall_count != '1))
                r_stall_count <= r_stall_count + CNT_W'(1);
            if (w_redirect && (r_flush_count != '1))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign stall_err   = r_err | w_err_set;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations. The
// driver pushes each vector's expected outputs into a queue; a monitor pops
// and compares them on the falling edge of the same cycle.
module tb_hazard_ctrl;

    typedef struct {
        logic       rst;
        logic [4:0] rs1_d, rs2_d;
        logic       branch_d;
        logic [4:0] rs1_e, rs2_e, rd_e;
        logic       rw_e, load_e;
        logic [4:0] rd_m;
        logic       rw_m;
        logic [4:0] rd_w;
        logic       rw_w;
        logic       br_e, jal_e, jalr_e, clr;
    } vin_t;

    typedef struct {
        string       name;
        logic        stall_f, stall_d, flush_d, flush_e;
        logic [1:0]  fa_dec, fb_dec, fa_e, fb_e;
        logic        err;
        logic [15:0] sc, fc;
    } vexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  RS1_D = '0, RS2_D = '0, RS1_E = '0, RS2_E = '0, RD_E = '0, RD_M = '0, RDW = '0;
    logic        BranchD = 1'b0, RegWriteE = 1'b0, LoadE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic        Branch_resultE = 1'b0, JalE = 1'b0, JalrE = 1'b0, cnt_clr = 1'b0;
    logic        StallF, StallD, FlushD, FlushE, stall_err;
    logic [1:0]  ForwardAEDec, ForwardBEDec, ForwardAE, ForwardBE;
    logic [15:0] stall_count, flush_count;

    vexp_t q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .BranchD(BranchD),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
        .RegWriteE(RegWriteE), .LoadE(LoadE),
        .RD_M(RD_M), .RegWriteM(RegWriteM),
        .RDW(RDW), .RegWriteW(RegWriteW),
        .Branch_resultE(Branch_resultE), .JalE(JalE), .JalrE(JalrE),
        .cnt_clr(cnt_clr),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAEDec(ForwardAEDec), .ForwardBEDec(ForwardBEDec),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_err(stall_err), .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    initial begin
        vexp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, " StallF"},       32'(StallF),       32'(e.stall_f));
                check({e.name, " StallD"},       32'(StallD),       32'(e.stall_d));
                check({e.name, " FlushD"},       32'(FlushD),       32'(e.flush_d));
                check({e.name, " FlushE"},       32'(FlushE),       32'(e.flush_e));
                check({e.name, " ForwardAEDec"}, 32'(ForwardAEDec), 32'(e.fa_dec));
                check({e.name, " ForwardBEDec"}, 32'(ForwardBEDec), 32'(e.fb_dec));
                check({e.name, " ForwardAE"},    32'(ForwardAE),    32'(e.fa_e));
                check({e.name, " ForwardBE"},    32'(ForwardBE),    32'(e.fb_e));
                check({e.name, " stall_err"},    32'(stall_err),    32'(e.err));
                check({e.name, " stall_count"},  32'(stall_count),  32'(e.sc));
                check({e.name, " flush_count"},  32'(flush_count),  32'(e.fc));
            end
        end
    end

    function automatic vin_t idle();
        vin_t v;
        v = '{rst: 1'b1, default: '0};
        return v;
    endfunction

    function automatic vin_t load_use();
        vin_t v;
        v = idle();
        v.load_e = 1'b1; v.rw_e = 1'b1; v.rd_e = 5'd5; v.rs1_d = 5'd5;
        return v;
    endfunction

    function automatic vexp_t ex0(input string n, input int sc, input int fc, input logic err);
        vexp_t e;
        e.name = n;
        e.stall_f = 1'b0; e.stall_d = 1'b0; e.flush_d = 1'b0; e.flush_e = 1'b0;
        e.fa_dec = 2'b00; e.fb_dec = 2'b00; e.fa_e = 2'b00; e.fb_e = 2'b00;
        e.err = err; e.sc = 16'(sc); e.fc = 16'(fc);
        return e;
    endfunction

    function automatic vexp_t boot(input vexp_t e);
        vexp_t r = e;
        r.stall_f = 1'b1; r.flush_d = 1'b1; r.flush_e = 1'b1;
        return r;
    endfunction

    function automatic vexp_t stall(input vexp_t e);
        vexp_t r = e;
        r.stall_f = 1'b1; r.stall_d = 1'b1; r.flush_e = 1'b1;
        return r;
    endfunction

    function automatic vexp_t flush(input vexp_t e);
        vexp_t r = e;
        r.flush_d = 1'b1; r.flush_e = 1'b1;
        return r;
    endfunction

    // Driver: one vector per cycle, applied just after the rising edge.
    task automatic apply(input vin_t v, input vexp_t e);
        @(posedge clk);
        #1;
        rst = v.rst;
        RS1_D = v.rs1_d; RS2_D = v.rs2_d; BranchD = v.branch_d;
        RS1_E = v.rs1_e; RS2_E = v.rs2_e; RD_E = v.rd_e;
        RegWriteE = v.rw_e; LoadE = v.load_e;
        RD_M = v.rd_m; RegWriteM = v.rw_m; RDW = v.rd_w; RegWriteW = v.rw_w;
        Branch_resultE = v.br_e; JalE = v.jal_e; JalrE = v.jalr_e; cnt_clr = v.clr;
        q.push_back(e);
    endtask

    initial begin
        vin_t  v;
        vexp_t e;

        // Reset: boot outputs, forwarding still live.
        v = idle(); v.rst = 1'b0; v.rs1_d = 5'd4; v.rd_w = 5'd4; v.rw_w = 1'b1;
        e = boot(ex0("rst", 0, 0, 1'b0)); e.fa_dec = 2'b01;
        apply(v, e);
        // Two boot cycles ignore redirect and hazards.
        v = idle(); v.jal_e = 1'b1;
        apply(v, boot(ex0("boot1", 0, 0, 1'b0)));
        apply(load_use(), boot(ex0("boot2", 0, 0, 1'b0)));
        apply(idle(), ex0("run0", 0, 0, 1'b0));

        // Load-use: one stall, then Memory-stage forwarding.
        apply(load_use(), stall(ex0("lu", 0, 0, 1'b0)));
        v = idle(); v.rd_m = 5'd5; v.rw_m = 1'b1; v.rs1_e = 5'd5;
        e = ex0("lu_fwd", 1, 0, 1'b0); e.fa_e = 2'b10;
        apply(v, e);

        // Branch after ALU op: stall on E match, stall on M match, then forward from W.
        v = idle(); v.branch_d = 1'b1; v.rs2_d = 5'd7; v.rw_e = 1'b1; v.rd_e = 5'd7;
        apply(v, stall(ex0("br1", 1, 0, 1'b0)));
        v = idle(); v.branch_d = 1'b1; v.rs2_d = 5'd7; v.rw_m = 1'b1; v.rd_m = 5'd7;
        apply(v, stall(ex0("br2", 2, 0, 1'b0)));
        v = idle(); v.branch_d = 1'b1; v.rs2_d = 5'd7; v.rw_w = 1'b1; v.rd_w = 5'd7;
        e = ex0("br3", 3, 0, 1'b0); e.fb_dec = 2'b01;
        apply(v, e);

        // Redirect beats a load-use hazard.
        v = load_use(); v.jal_e = 1'b1;
        apply(v, flush(ex0("redir", 3, 0, 1'b0)));
        apply(idle(), ex0("post_redir", 3, 1, 1'b0));

        // Forwarding priority and x0.
        v = idle(); v.rd_m = 5'd3; v.rw_m = 1'b1; v.rd_w = 5'd3; v.rw_w = 1'b1;
        v.rs1_e = 5'd3; v.rs2_e = 5'd3; v.rs1_d = 5'd3;
        e = ex0("fwd_mw", 3, 1, 1'b0); e.fa_e = 2'b10; e.fb_e = 2'b10; e.fa_dec = 2'b01;
        apply(v, e);
        v = idle(); v.rd_m = 5'd3; v.rd_w = 5'd3; v.rw_w = 1'b1; v.rs1_e = 5'd3; v.rs2_e = 5'd9;
        e = ex0("fwd_w", 3, 1, 1'b0); e.fa_e = 2'b01;
        apply(v, e);
        v = idle(); v.rw_m = 1'b1; v.rw_w = 1'b1; v.rw_e = 1'b1; v.load_e = 1'b1; v.branch_d = 1'b1;
        apply(v, ex0("x0", 3, 1, 1'b0));
        v = idle(); v.branch_d = 1'b1; v.rs1_d = 5'd8; v.rd_e = 5'd8; v.rd_m = 5'd8; v.rs1_e = 5'd8;
        apply(v, ex0("no_we", 3, 1, 1'b0));

        // Stall overrun: third consecutive stall cycle flags the error.
        apply(load_use(), stall(ex0("err1", 3, 1, 1'b0)));
        apply(load_use(), stall(ex0("err2", 4, 1, 1'b0)));
        apply(load_use(), stall(ex0("err3", 5, 1, 1'b1)));
        v = load_use(); v.jalr_e = 1'b1;
        apply(v, flush(ex0("err_redir", 6, 1, 1'b1)));

        // Counter clear.
        v = idle(); v.clr = 1'b1;
        apply(v, ex0("clr", 6, 2, 1'b1));
        apply(idle(), ex0("post_clr", 0, 0, 1'b1));

        // Reset asserted mid-stall.
        apply(load_use(), stall(ex0("ms1", 0, 0, 1'b1)));
        v = load_use(); v.rst = 1'b0;
        apply(v, boot(ex0("ms_rst", 0, 0, 1'b0)));
        apply(idle(), boot(ex0("ms_b1", 0, 0, 1'b0)));
        apply(idle(), boot(ex0("ms_b2", 0, 0, 1'b0)));
        apply(idle(), ex0("ms_run", 0, 0, 1'b0));
        apply(load_use(), stall(ex0("ms_lu", 0, 0, 1'b0)));
        apply(idle(), ex0("end", 1, 0, 1'b0));

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
